// File: rtl/sync_type1_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_type1_rx_if
//  Description : Downstream valid/ready word stream leaving sync_type1_rx.
//                The producer (the receiver block) uses the master modport;
//                the consumer uses the slave modport.
//  Signals     : out_data  - head-of-FIFO word (W bits)
//                out_valid - a word is available
//                out_ready - consumer accepts out_data this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_type1_rx_if #(
    parameter int W = 32
) ();
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/sync_type1_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sync_type1_rx
//  Description : Receive end of a toggle-request / toggle-acknowledge bus
//                crossing. The remote sender places a word on cross_in and
//                flips req_tgl_in. The request toggle is synchronised into the
//                clk_out domain, the (protocol-stable) word is captured into a
//                small first-word-fall-through FIFO and ack_tgl_out is flipped
//                back to the sender. When the FIFO is full the ack is simply
//                withheld, so no word can ever be dropped.
//  Ports       : clk_out      - sole clock
//                rst_out      - synchronous, active-high reset
//                req_tgl_in   - asynchronous request toggle from the sender
//                cross_in     - asynchronous data word, stable while pending
//                ack_tgl_out  - registered acknowledge toggle to the sender
//                out_if       - valid/ready output stream (master modport)
//                fifo_level   - current FIFO occupancy, 0..DEPTH
//                stall_cnt    - saturating count of cycles in WAIT_SPACE
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_type1_rx #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16
) (
    input  wire logic                     clk_out,
    input  wire logic                     rst_out,
    input  wire logic                     req_tgl_in,
    input  wire logic [W-1:0]             cross_in,
    output logic                          ack_tgl_out,
    sync_type1_rx_if.master               out_if,
    output logic [$clog2(DEPTH):0]        fifo_level,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int AW = $clog2(DEPTH);   // FIFO address width
    localparam int PW = AW + 1;          // pointer width (extra wrap bit)

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SPACE = 2'd1,
        S_GUARD      = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Request synchroniser. Only the single toggle bit is synchronised; the
    // data word is sampled at the write edge, which by construction is at
    // least SYNC_STAGES cycles after the toggle, so it is already stable.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_sync;

    always_ff @(posedge clk_out) begin
        if (rst_out) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_tgl_in};
        end
    end

    assign w_req_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Handshake and FIFO state
    // ------------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_req_seen;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [W-1:0]   r_mem [DEPTH];

    logic           w_pending;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_space;
    logic           w_push;
    logic           w_stall_inc;

    // A request is outstanding while the synchronised toggle differs from
    // the last toggle value that was accepted.
    assign w_pending = (w_req_sync != r_req_seen);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Pops are qualified by valid, so a pop request on an empty FIFO is a
    // no-op. A pop in the same cycle frees a slot for a simultaneous push,
    // which lets a full FIFO keep streaming without stalling the sender.
    assign w_pop   = out_if.out_valid && out_if.out_ready;
    assign w_space = !w_full || w_pop;

    // ------------------------------------------------------------------------
    // FSM: next state and per-cycle actions
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_stall_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pending) begin
                    if (w_space) begin
                        w_push = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_SPACE;
                    end
                end
            end
            S_WAIT_SPACE: begin
                w_stall_inc = 1'b1;
                if (w_pending && w_space) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_GUARD;
                end
            end
            // One dead cycle after a backpressured write keeps the ack rate
            // bounded while the consumer is only trickling words out.
            S_GUARD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (rst_out) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Accept side: each push consumes the pending request and answers it by
    // flipping the ack toggle on the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_out) begin
        if (rst_out) begin
            r_req_seen  <= 1'b0;
            ack_tgl_out <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            if (w_push) begin
                r_req_seen  <= w_req_sync;
                ack_tgl_out <= ~ack_tgl_out;
                r_wr_ptr    <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: nothing is visible until a push has occurred.
    always_ff @(posedge clk_out) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= cross_in;
        end
    end

    // ------------------------------------------------------------------------
    // Stall counter: saturates at all-ones rather than wrapping.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_out) begin
        if (rst_out) begin
            stall_cnt <= '0;
        end else if (w_stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The head word is forced to zero while empty so that the bus
    // never exposes stale or uninitialised storage.
    // ------------------------------------------------------------------------
    assign out_if.out_valid = !w_empty;
    assign out_if.out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level       = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_sync_type1_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_type1_rx
//  Description : Directed self-checking bench for sync_type1_rx. Instance u_d0
//                uses SYNC_STAGES=2, DEPTH=4, CNT_W=4; instance u_d1 uses
//                SYNC_STAGES=4 to check the longer synchroniser latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_type1_rx;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [31:0] cross0;
    logic        ack0;
    logic [2:0]  level0;
    logic [3:0]  stall0;
    logic        req1;
    logic [31:0] cross1;
    logic        ack1;
    logic [2:0]  level1;
    logic [15:0] stall1;

    int checks   = 0;
    int failures = 0;

    sync_type1_rx_if #(.W(32)) bus0 ();
    sync_type1_rx_if #(.W(32)) bus1 ();

    sync_type1_rx #(.W(32), .SYNC_STAGES(2), .DEPTH(4), .CNT_W(4)) u_d0 (
        .clk_out     (clk),
        .rst_out     (rst),
        .req_tgl_in  (req0),
        .cross_in    (cross0),
        .ack_tgl_out (ack0),
        .out_if      (bus0),
        .fifo_level  (level0),
        .stall_cnt   (stall0)
    );

    sync_type1_rx #(.W(32), .SYNC_STAGES(4), .DEPTH(4), .CNT_W(16)) u_d1 (
        .clk_out     (clk),
        .rst_out     (rst),
        .req_tgl_in  (req1),
        .cross_in    (cross1),
        .ack_tgl_out (ack1),
        .out_if      (bus1),
        .fifo_level  (level1),
        .stall_cnt   (stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents a word, flips the request and counts the
    // negedges until the matching ack comes back (bounded).
    task automatic send_wait(input logic [31:0] word, input string tag);
        int n;
        n      = 0;
        cross0 = word;
        req0   = ~req0;
        while ((ack0 !== req0) && (n < 8)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'd3);
    endtask

    initial begin
        rst    = 1'b1;
        req0   = 1'b0;
        cross0 = '0;
        req1   = 1'b0;
        cross1 = '0;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- reset state ----
        chk("rst_ack",   64'(ack0),           64'd0);
        chk("rst_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_data",  64'(bus0.out_data),  64'd0);
        chk("rst_level", 64'(level0),         64'd0);
        chk("rst_stall", 64'(stall0),         64'd0);

        // ---- single word, consumer ready ----
        cross0 = 32'hDEADBEEF;
        req0   = 1'b1;
        bus0.out_ready = 1'b1;
        @(negedge clk);                              // after edge k
        @(negedge clk);                              // after edge k+1
        chk("single_ack_early", 64'(ack0), 64'd0);
        @(negedge clk);                              // after edge k+2
        chk("single_ack",   64'(ack0),           64'd1);
        chk("single_valid", 64'(bus0.out_valid), 64'd1);
        chk("single_data",  64'(bus0.out_data),  64'hDEADBEEF);
        chk("single_level", 64'(level0),         64'd1);
        @(negedge clk);
        chk("single_drain_valid", 64'(bus0.out_valid), 64'd0);
        chk("single_drain_level", 64'(level0),         64'd0);
        bus0.out_ready = 1'b0;

        // ---- fill to DEPTH, fifth word backpressured ----
        send_wait(32'd1, "fill_rt1");
        send_wait(32'd2, "fill_rt2");
        send_wait(32'd3, "fill_rt3");
        send_wait(32'd4, "fill_rt4");
        chk("fill_level", 64'(level0), 64'd4);
        cross0 = 32'd5;
        req0   = ~req0;
        repeat (10) @(negedge clk);
        chk("bp_ack_withheld", 64'(ack0 != req0), 64'd1);
        chk("bp_level",        64'(level0),       64'd4);
        chk("bp_stall",        64'(stall0),       64'd7);
        repeat (15) @(negedge clk);
        chk("stall_saturate",  64'(stall0),       64'hF);
        chk("bp_head",         64'(bus0.out_data), 64'd1);

        // one-cycle pop frees a slot; the fifth word lands on the same edge
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        chk("bp_release_ack",   64'(ack0),           64'(req0));
        chk("bp_release_level", 64'(level0),         64'd4);
        chk("bp_release_head",  64'(bus0.out_data),  64'd2);
        chk("stall_no_wrap",    64'(stall0),         64'hF);

        // drain, order 2,3,4,5
        bus0.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("order_valid", 64'(bus0.out_valid), 64'd1);
            chk("order_data",  64'(bus0.out_data),  64'(i));
            @(negedge clk);
        end
        bus0.out_ready = 1'b0;
        chk("drained_valid", 64'(bus0.out_valid), 64'd0);
        chk("drained_level", 64'(level0),         64'd0);

        // ---- simultaneous push and pop while full ----
        send_wait(32'h10, "full_rt0");
        send_wait(32'h11, "full_rt1");
        send_wait(32'h12, "full_rt2");
        send_wait(32'h13, "full_rt3");
        cross0 = 32'h14;
        req0   = ~req0;
        @(negedge clk);                              // after edge k
        @(negedge clk);                              // after edge k+1
        chk("pp_ack_before", 64'(ack0 != req0), 64'd1);
        bus0.out_ready = 1'b1;
        @(negedge clk);                              // after edge k+2
        bus0.out_ready = 1'b0;
        chk("pp_ack",   64'(ack0),          64'(req0));
        chk("pp_level", 64'(level0),        64'd4);
        chk("pp_head",  64'(bus0.out_data), 64'h11);

        // ---- reset mid-flight ----
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        chk("mid_level3", 64'(level0), 64'd3);
        cross0 = 32'h20;
        req0   = ~req0;                              // request now pending
        @(negedge clk);
        rst  = 1'b1;
        req0 = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(bus0.out_valid), 64'd0);
        chk("mid_rst_level", 64'(level0),         64'd0);
        chk("mid_rst_ack",   64'(ack0),           64'd0);
        chk("mid_rst_data",  64'(bus0.out_data),  64'd0);
        chk("mid_rst_stall", 64'(stall0),         64'd0);
        @(negedge clk);
        rst    = 1'b0;
        cross0 = 32'hABCD0123;
        @(negedge clk);                              // after edge k
        @(negedge clk);                              // after edge k+1
        chk("post_rst_ack_early", 64'(ack0), 64'd0);
        @(negedge clk);                              // after edge k+2
        chk("post_rst_ack",   64'(ack0),          64'd1);
        chk("post_rst_level", 64'(level0),        64'd1);
        chk("post_rst_data",  64'(bus0.out_data), 64'hABCD0123);
        repeat (5) @(negedge clk);
        chk("post_rst_one_word", 64'(level0), 64'd1);
        chk("post_rst_ack_hold", 64'(ack0),   64'd1);
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        chk("post_rst_drain", 64'(level0), 64'd0);

        // ---- four-stage synchroniser latency ----
        cross1 = 32'h5A5A5A5A;
        req1   = 1'b1;
        repeat (4) @(negedge clk);                   // after edges k..k+3
        chk("sync4_ack_early",   64'(ack1),           64'd0);
        chk("sync4_valid_early", 64'(bus1.out_valid), 64'd0);
        @(negedge clk);                              // after edge k+4
        chk("sync4_ack",   64'(ack1),           64'd1);
        chk("sync4_valid", 64'(bus1.out_valid), 64'd1);
        chk("sync4_data",  64'(bus1.out_data),  64'h5A5A5A5A);
        chk("sync4_level", 64'(level1),         64'd1);
        chk("sync4_stall", 64'(stall1),         64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_type1_rx.md
Name: sync_type1_rx

Overview:
- Receive end of a toggle-request / toggle-acknowledge bus crossing, clocked entirely in the destination domain.
- A remote sender in another clock domain places a word on cross_in and flips req_tgl_in. This block synchronises the request, captures the stable word into a small first-word-fall-through FIFO, and flips ack_tgl_out back to the sender.
- Downstream logic consumes words through a valid/ready interface.
- Used wherever a multi-bit register or stream crosses into the domain of clk_out.

Parameters:
- W, 32, data width of cross_in and out_data.
- SYNC_STAGES, 2, flip-flops in the request synchroniser; legal range 2..4.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk_out  in  1  sole clock of the block.
- rst_out  in  1  synchronous, active-high reset.
- req_tgl_in  in  1  asynchronous request toggle from the sender; each transition means one new word.
- cross_in  in  W  asynchronous data; the sender holds it stable from its req toggle until it sees the matching ack toggle.
- ack_tgl_out  out  1  registered acknowledge toggle to the sender.
- out_data  out  W  head-of-FIFO word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- fifo_level  out  log2(DEPTH)+1  current occupancy.
- stall_cnt  out  CNT_W  saturating count of cycles spent in WAIT_SPACE.

Behaviour:
- Reset (synchronous, active-high):
  - Synchroniser chain, req_seen, ack_tgl_out, FIFO pointers, fifo_level and stall_cnt all go to 0.
  - out_valid goes to 0, the FSM goes to IDLE, and out_data reads 0.
- Synchroniser:
  - req_tgl_in passes through SYNC_STAGES registers to give req_sync.
  - A pending request exists when req_sync != req_seen.
  - cross_in is never synchronised bit-wise. It is sampled only at the write edge, which is at least SYNC_STAGES cycles after the toggle, so it is stable by protocol.
- FSM, 3 states:
  - IDLE: if a request is pending and the FIFO is not full (or a pop occurs this cycle), then on the same edge write cross_in into the FIFO, set req_seen <= req_sync and toggle ack_tgl_out; stay in IDLE. If a request is pending and the FIFO is full with no pop, go to WAIT_SPACE.
  - WAIT_SPACE: stall_cnt increments each cycle, saturating at all-ones. When space exists (not full, or a pop this cycle), perform the write/ack actions above and go to GUARD.
  - GUARD: one cycle with no new write, then return to IDLE. This bounds the ack rate after backpressure.
  - Any undefined state encoding goes to IDLE.
- Latency:
  - A toggle sampled at edge k reaches req_sync at edge k+SYNC_STAGES-1.
  - The word is written and ack_tgl_out flips at edge k+SYNC_STAGES.
  - out_valid rises after that same edge if the FIFO was empty (FWFT, no extra register stage).
- FIFO:
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
  - A simultaneous push and pop when full is legal: occupancy is unchanged and out_data advances.
  - A pop when empty is ignored.
  - fifo_level = wr_ptr - rd_ptr, always in 0..DEPTH.
- Throughput:
  - At most one word per req/ack round trip.
  - No word is ever dropped, and there is no overflow path: backpressure is applied solely by withholding the ack.
- Reset mid-operation:
  - A pending request is discarded and the FIFO contents are lost.
  - If req_tgl_in is 1 when rst_out deasserts, it is treated as one new request, because req_seen is 0. The sender is required to be reset in the same system reset.

Test Plan:
- Single word: after reset, set cross_in=32'hDEADBEEF and flip req_tgl_in 0->1 with out_ready=1 -> at edge +2 ack_tgl_out=1, out_valid=1 with out_data=32'hDEADBEEF for one cycle, then fifo_level=0.
- Fill and backpressure: DEPTH=4, out_ready=0, send words 1..5 with the sender waiting for ack each time -> four acks, the fifth is withheld, the FSM sits in WAIT_SPACE and stall_cnt counts; raising out_ready for one cycle pops 1, the fifth word is written on that edge, ack flips, GUARD lasts one cycle, and the output order is 1,2,3,4,5.
- Push and pop when full: FIFO holds 4 entries, a request is pending and out_ready=1 -> fifo_level stays 4, ack flips, out_data advances by one word.
- Stall counter saturation: CNT_W=4, hold the FIFO full for 20 cycles -> stall_cnt=4'hF and does not wrap.
- Reset mid-flight: assert rst_out with 3 words queued and a request pending -> next cycle out_valid=0, fifo_level=0, ack_tgl_out=0; with req_tgl_in=1 at deassert, exactly one word is captured at edge +2.
- Sync depth: SYNC_STAGES=4 -> ack and write occur 4 edges after the toggle is first sampled.
